// File: rtl/watch_dp_if.sv
// Control-unit <-> timekeeping datapath bundle: run enable, adjust ticks and time outputs.
interface watch_dp_if;
  logic       run;
  logic       tick_sec_u;
  logic       tick_sec_d;
  logic       tick_min_u;
  logic       tick_min_d;
  logic       tick_hour_u;
  logic       tick_hour_d;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic       tick_1hz;

  // Control side: drives run/adjust ticks, consumes the time fields.
  modport master (
    output run, tick_sec_u, tick_sec_d, tick_min_u, tick_min_d, tick_hour_u, tick_hour_d,
    input  msec, sec, min, hour, tick_1hz
  );

  // Datapath side.
  modport slave (
    input  run, tick_sec_u, tick_sec_d, tick_min_u, tick_min_d, tick_hour_u, tick_hour_d,
    output msec, sec, min, hour, tick_1hz
  );
endinterface

// File: rtl/watch_dp.sv
// Watch timekeeping datapath: 10 ms timebase divider feeding a msec/sec/min/hour
// counter chain, with per-field up/down adjust ticks from the control unit.
module watch_dp #(
  parameter int unsigned FCOUNT    = 1_000_000,
  parameter int unsigned HOUR_INIT = 12
) (
  input  logic       clk,
  input  logic       rst,
  watch_dp_if.slave  bus
);

  localparam int unsigned DIV_W = (FCOUNT > 1) ? $clog2(FCOUNT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FCOUNT - 1);

  logic [DIV_W-1:0] div_q;
  logic [6:0]       msec_q;
  logic [5:0]       sec_q, min_q;
  logic [4:0]       hour_q;
  logic             t1hz_q;

  logic             c_ms;
  logic             co_ms, co_sec, co_min;
  logic [6:0]       msec_n;
  logic [5:0]       sec_n, min_n;
  logic [4:0]       hour_n;

  // (cur + cin + up - down) wrapped into 0..m-1; the signed headroom covers -1 and m+1.
  function automatic logic [6:0] fld_next(input logic [6:0] cur, input logic cin,
                                          input logic up, input logic dn, input logic [6:0] m);
    logic signed [8:0] s;
    logic signed [8:0] ms;
    ms = $signed({2'b00, m});
    s  = $signed({2'b00, cur}) + $signed({8'd0, cin}) + $signed({8'd0, up})
         - $signed({8'd0, dn});
    if (s < 0)
      s = s + ms;
    else if (s >= ms)
      s = s - ms;
    return s[6:0];
  endfunction

  assign c_ms = bus.run && (div_q == DIV_LAST);

  // Next field values and ripple carries; an adjust tick on a field blocks its carry-out.
  always_comb begin
    co_ms  = c_ms && (msec_q == 7'd99);
    co_sec = co_ms && (sec_q == 6'd59) && !bus.tick_sec_u && !bus.tick_sec_d;
    co_min = co_sec && (min_q == 6'd59) && !bus.tick_min_u && !bus.tick_min_d;
    msec_n = fld_next(msec_q, c_ms, 1'b0, 1'b0, 7'd100);
    sec_n  = 6'(fld_next({1'b0, sec_q}, co_ms, bus.tick_sec_u, bus.tick_sec_d, 7'd60));
    min_n  = 6'(fld_next({1'b0, min_q}, co_sec, bus.tick_min_u, bus.tick_min_d, 7'd60));
    hour_n = 5'(fld_next({2'b00, hour_q}, co_min, bus.tick_hour_u, bus.tick_hour_d, 7'd24));
  end

  // Timebase divider: counts while run is high, holds its partial period otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      div_q <= '0;
    else if (bus.run)
      div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
  end

  // Time field registers and the registered 1 Hz pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msec_q <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= 5'(HOUR_INIT);
      t1hz_q <= 1'b0;
    end else begin
      msec_q <= msec_n;
      sec_q  <= sec_n;
      min_q  <= min_n;
      hour_q <= hour_n;
      t1hz_q <= co_ms;
    end
  end

  assign bus.msec     = msec_q;
  assign bus.sec      = sec_q;
  assign bus.min      = min_q;
  assign bus.hour     = hour_q;
  assign bus.tick_1hz = t1hz_q;

endmodule

// File: tb/tb_watch_dp.sv
// Bench for watch_dp: directed scenarios plus random run/adjust traffic, all
// compared every cycle against a field-arithmetic reference model.
module tb_watch_dp;
  localparam int FC = 10;
  localparam int HI = 12;
  localparam int MOD[4] = '{100, 60, 60, 24};

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   pulse_cnt = 0;

  watch_dp_if bus();

  watch_dp #(.FCOUNT(FC), .HOUR_INIT(HI)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: fields as integers, wrap by modulo, carries per the field rules.
  int m_div = 0;
  int mf[4] = '{0, 0, 0, HI};
  int m_t1 = 0;
  int up_v[4];
  int dn_v[4];
  int carry, nv;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_div = 0;
      mf    = '{0, 0, 0, HI};
      m_t1  = 0;
    end else begin
      up_v  = '{0, int'(bus.tick_sec_u), int'(bus.tick_min_u), int'(bus.tick_hour_u)};
      dn_v  = '{0, int'(bus.tick_sec_d), int'(bus.tick_min_d), int'(bus.tick_hour_d)};
      carry = 0;
      if (bus.run) begin
        if (m_div == FC - 1) begin
          m_div = 0;
          carry = 1;
        end else begin
          m_div++;
        end
      end
      for (int i = 0; i < 4; i++) begin
        nv    = mf[i] + carry + up_v[i] - dn_v[i];
        nv    = ((nv % MOD[i]) + MOD[i]) % MOD[i];
        carry = (carry == 1 && mf[i] == MOD[i] - 1 && up_v[i] == 0 && dn_v[i] == 0) ? 1 : 0;
        if (i == 0) m_t1 = carry;
        mf[i] = nv;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    check("msec", int'(bus.msec), mf[0]);
    check("sec", int'(bus.sec), mf[1]);
    check("min", int'(bus.min), mf[2]);
    check("hour", int'(bus.hour), mf[3]);
    check("tick_1hz", int'(bus.tick_1hz), m_t1);
  end

  always @(negedge clk)
    if (rst && bus.tick_1hz) pulse_cnt++;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_up(input int idx, input logic v);
    case (idx)
      1: bus.tick_sec_u  = v;
      2: bus.tick_min_u  = v;
      3: bus.tick_hour_u = v;
      default: ;
    endcase
  endtask

  // Hold the field's up tick for as many cycles as needed to reach target (run must be 0).
  task automatic set_field(input int idx, input int target);
    int k;
    k = (((target - mf[idx]) % MOD[idx]) + MOD[idx]) % MOD[idx];
    if (k > 0) begin
      drive_up(idx, 1'b1);
      tick(k);
      drive_up(idx, 1'b0);
    end
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s, input int ms);
    check({tag, "_hour"}, int'(bus.hour), h);
    check({tag, "_min"}, int'(bus.min), m);
    check({tag, "_sec"}, int'(bus.sec), s);
    check({tag, "_msec"}, int'(bus.msec), ms);
  endtask

  initial begin
    int p0, ms0, mn0, found;
    bus.run = 1'b0;
    bus.tick_sec_u = 1'b0;  bus.tick_sec_d = 1'b0;
    bus.tick_min_u = 1'b0;  bus.tick_min_d = 1'b0;
    bus.tick_hour_u = 1'b0; bus.tick_hour_d = 1'b0;

    // Reset held, then release, count a bit and reset again mid-count.
    tick(3);
    check_time("in_reset", 12, 0, 0, 0);
    check("in_reset_t1hz", int'(bus.tick_1hz), 0);
    rst = 1'b1;
    bus.run = 1'b1;
    tick(5);
    #2 rst = 1'b0;
    #1 check_time("midcount_reset", 12, 0, 0, 0);
    tick(2);
    rst = 1'b1;
    p0 = pulse_cnt;
    tick(9);
    check("first_ms_early", int'(bus.msec), 0);
    tick(1);
    check("first_ms", int'(bus.msec), 1);
    tick(989);
    check_time("edge999", 12, 0, 0, 99);
    check("pulses_999", pulse_cnt - p0, 0);
    tick(1);
    check_time("edge1000", 12, 0, 1, 0);
    check("t1hz_1000", int'(bus.tick_1hz), 1);
    tick(999);
    check("pulses_1999", pulse_cnt - p0, 1);
    tick(1);
    check("sec_2000", int'(bus.sec), 2);
    check("t1hz_2000", int'(bus.tick_1hz), 1);

    // Full-day rollover.
    bus.run = 1'b0;
    set_field(3, 23);
    set_field(2, 59);
    set_field(1, 59);
    bus.run = 1'b1;
    found = 0;
    for (int i = 0; i < 1100; i++) begin
      if (bus.tick_1hz) begin
        found = 1;
        break;
      end
      tick(1);
    end
    check("rollover_wait", found, 1);
    check_time("rollover", 0, 0, 0, 0);

    // Adjust wraps never carry into neighbours.
    bus.run = 1'b0;
    set_field(1, 59);
    set_field(2, 5);
    bus.tick_sec_u = 1'b1; tick(1); bus.tick_sec_u = 1'b0;
    check("secwrap_sec", int'(bus.sec), 0);
    check("secwrap_min", int'(bus.min), 5);
    set_field(3, 3);
    set_field(2, 0);
    bus.tick_min_d = 1'b1; tick(1); bus.tick_min_d = 1'b0;
    check("minwrap_min", int'(bus.min), 59);
    check("minwrap_hour", int'(bus.hour), 3);
    set_field(3, 0);
    bus.tick_hour_d = 1'b1; tick(1); bus.tick_hour_d = 1'b0;
    check("hourwrap_hour", int'(bus.hour), 23);

    // Carry and adjust on sec in the same edge.
    set_field(1, 59);
    set_field(2, 10);
    bus.run = 1'b1;
    found = 0;
    for (int i = 0; i < 1200; i++) begin
      if (mf[0] == 99 && m_div == FC - 1) begin
        found = 1;
        break;
      end
      tick(1);
    end
    check("collide_wait", found, 1);
    bus.tick_sec_u = 1'b1; tick(1); bus.tick_sec_u = 1'b0;
    check("collide_sec", int'(bus.sec), 1);
    check("collide_min", int'(bus.min), 10);
    check("collide_msec", int'(bus.msec), 0);
    check("collide_t1hz", int'(bus.tick_1hz), 1);

    // Up and down together cancel.
    bus.run = 1'b0;
    set_field(1, 20);
    bus.tick_sec_u = 1'b1; bus.tick_sec_d = 1'b1;
    tick(1);
    bus.tick_sec_u = 1'b0; bus.tick_sec_d = 1'b0;
    check("cancel_sec", int'(bus.sec), 20);

    // Freeze at divider 7, adjust while frozen, then resume the partial period.
    bus.run = 1'b1;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_div == 7) begin
        found = 1;
        break;
      end
      tick(1);
    end
    check("freeze_wait", found, 1);
    bus.run = 1'b0;
    ms0 = mf[0];
    mn0 = mf[2];
    tick(20);
    bus.tick_min_u = 1'b1; tick(1); bus.tick_min_u = 1'b0;
    tick(29);
    check("freeze_msec", int'(bus.msec), ms0);
    check("freeze_min_adj", int'(bus.min), (mn0 + 1) % 60);
    bus.run = 1'b1;
    tick(2);
    check("resume_hold", int'(bus.msec), ms0);
    tick(1);
    check("resume_inc", int'(bus.msec), (ms0 + 1) % 100);

    // Asynchronous reset between edges at 07:33:21.45.
    found = 0;
    for (int i = 0; i < 1200; i++) begin
      if (mf[0] == 45) begin
        found = 1;
        break;
      end
      tick(1);
    end
    check("ms45_wait", found, 1);
    bus.run = 1'b0;
    set_field(3, 7);
    set_field(2, 33);
    set_field(1, 21);
    check_time("pre_reset", 7, 33, 21, 45);
    #2 rst = 1'b0;
    #1 check_time("async_reset", 12, 0, 0, 0);
    check("async_reset_t1hz", int'(bus.tick_1hz), 0);
    tick(2);
    rst = 1'b1;

    // Random run gating and adjust traffic, including collisions.
    for (int i = 0; i < 4000; i++) begin
      bus.run         = ($urandom_range(0, 9) != 0);
      bus.tick_sec_u  = ($urandom_range(0, 15) == 0);
      bus.tick_sec_d  = ($urandom_range(0, 15) == 0);
      bus.tick_min_u  = ($urandom_range(0, 15) == 0);
      bus.tick_min_d  = ($urandom_range(0, 15) == 0);
      bus.tick_hour_u = ($urandom_range(0, 15) == 0);
      bus.tick_hour_d = ($urandom_range(0, 15) == 0);
      tick(1);
    end
    bus.tick_sec_u = 1'b0;  bus.tick_sec_d = 1'b0;
    bus.tick_min_u = 1'b0;  bus.tick_min_d = 1'b0;
    bus.tick_hour_u = 1'b0; bus.tick_hour_d = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
